// File: rtl/rob_pkg.sv
// rob_pkg: shared defaults, FSM encoding and round-robin helper for the ROB controller
package rob_pkg;
    localparam int DATA_W_DEF       = 32;
    localparam int FLUSH_CYCLES_DEF = 2;
    typedef enum logic {ST_FLUSH = 1'b0, ST_RUN = 1'b1} state_t;
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction
endpackage

// File: rtl/rob_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a registered priority pointer
module rr_arbiter
    import rob_pkg::*;
#(
    parameter int NUM_FU = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_FU-1:0] req,
    input  logic              advance,
    input  logic              clear,
    output logic [NUM_FU-1:0] grant
);
    localparam int PW = $clog2(NUM_FU);
    logic [PW-1:0] ptr_q, ptr_d, gidx, idx;
    // walk from the far end so the requester closest to the pointer wins
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + i) % NUM_FU);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
        ptr_d = clear ? '0 : advance ? PW'(rr_next(int'(gidx), NUM_FU)) : ptr_q;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
endmodule

// File: rtl/rob_ctrl.sv
// rob_ctrl: gates dispatch, arbitrates FU completions, drives commit and sequences ROB clear
module rob_ctrl
    import rob_pkg::*;
#(
    parameter int NUM_FU       = 3,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     disp_valid,
    input  logic [DATA_W-1:0]        disp_instr,
    output logic                     disp_ready,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*DATA_W-1:0] fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_val,
    output logic [NUM_FU-1:0]        fu_grant,
    output logic                     commit_valid,
    output logic [DATA_W-1:0]        commit_instr,
    output logic [DATA_W-1:0]        commit_val,
    input  logic                     commit_ready,
    output logic [31:0]              commit_count,
    output logic                     rob_push,
    output logic                     rob_pop,
    output logic                     rob_finish,
    output logic                     rob_reset,
    output logic [DATA_W-1:0]        rob_instr_in,
    output logic [DATA_W-1:0]        rob_finish_tag,
    output logic [DATA_W-1:0]        rob_finish_val,
    input  logic [DATA_W-1:0]        rob_head_instr,
    input  logic [DATA_W-1:0]        rob_head_val,
    input  logic                     rob_head_ready,
    input  logic                     rob_full,
    input  logic                     rob_empty
);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] count_q, count_d;
    logic        active;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_FLUSH) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? ST_RUN : ST_FLUSH;
        end else if (flush) begin
            state_d = ST_FLUSH;
            cnt_d   = 4'(FLUSH_CYCLES);
        end
        active       = (state_q == ST_RUN) && !flush;
        rob_reset    = (state_q == ST_FLUSH);
        disp_ready   = active && !rob_full;
        rob_push     = disp_valid && disp_ready;
        rob_instr_in = disp_instr;
        commit_valid = active && !rob_empty && rob_head_ready;
        rob_pop      = commit_valid && commit_ready;
        commit_instr = rob_head_instr;
        commit_val   = rob_head_val;
        count_d      = count_q + 32'(rob_pop);
        commit_count = count_q;
        rob_finish   = |fu_grant;
        rob_finish_tag = '0;
        rob_finish_val = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            rob_finish_tag = rob_finish_tag | (fu_tag[i*DATA_W +: DATA_W] & {DATA_W{fu_grant[i]}});
            rob_finish_val = rob_finish_val | (fu_val[i*DATA_W +: DATA_W] & {DATA_W{fu_grant[i]}});
        end
    end
    rr_arbiter #(.NUM_FU(NUM_FU)) u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    (fu_valid & {NUM_FU{active}}),
        .advance(rob_finish),
        .clear  ((state_q == ST_RUN) && flush),
        .grant  (fu_grant)
    );
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q <= ST_FLUSH;
            cnt_q   <= 4'(FLUSH_CYCLES);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed scenario tasks with hand-computed expectations for rob_ctrl
module tb_rob_ctrl;
    localparam int N = 3, W = 32;
    logic clock = 0, reset = 1, flush = 0, disp_valid = 0, commit_ready = 0;
    logic [W-1:0] disp_instr = 'h55, rob_head_instr = 0, rob_head_val = 0;
    logic rob_head_ready = 0, rob_full = 0, rob_empty = 1;
    logic [N-1:0] fu_valid = 0;
    logic [N*W-1:0] fu_tag, fu_val;
    logic disp_ready, commit_valid, rob_push, rob_pop, rob_finish, rob_reset;
    logic [N-1:0] fu_grant;
    logic [W-1:0] commit_instr, commit_val, rob_instr_in, rob_finish_tag, rob_finish_val;
    logic [31:0] commit_count;
    int checks = 0, errors = 0;

    rob_ctrl #(.NUM_FU(N), .DATA_W(W), .FLUSH_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .flush(flush), .disp_valid(disp_valid), .disp_instr(disp_instr),
        .disp_ready(disp_ready), .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_val(fu_val), .fu_grant(fu_grant),
        .commit_valid(commit_valid), .commit_instr(commit_instr), .commit_val(commit_val),
        .commit_ready(commit_ready), .commit_count(commit_count), .rob_push(rob_push), .rob_pop(rob_pop),
        .rob_finish(rob_finish), .rob_reset(rob_reset), .rob_instr_in(rob_instr_in),
        .rob_finish_tag(rob_finish_tag), .rob_finish_val(rob_finish_val), .rob_head_instr(rob_head_instr),
        .rob_head_val(rob_head_val), .rob_head_ready(rob_head_ready), .rob_full(rob_full), .rob_empty(rob_empty)
    );

    always #5 clock = ~clock;

    initial for (int i = 0; i < N; i++) begin
        fu_tag[i*W +: W] = 32'h100 + i;
        fu_val[i*W +: W] = 32'h200 + i;
    end

    task automatic test_reset();
        #1;
        checks++; if (rob_reset !== 1'b1) begin errors++; $display("FAIL reset_rob_reset got %b want 1", rob_reset); end
        checks++; if (disp_ready !== 1'b0 || fu_grant !== 3'b000 || commit_valid !== 1'b0) begin errors++; $display("FAIL reset_handshake got ready=%b grant=%b cv=%b want 0", disp_ready, fu_grant, commit_valid); end
        checks++; if (commit_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", commit_count); end
        @(negedge clock); reset = 0; #1;
        checks++; if (rob_reset !== 1'b1) begin errors++; $display("FAIL flush_seq0 got %b want 1", rob_reset); end
        @(negedge clock); #1;
        checks++; if (rob_reset !== 1'b1) begin errors++; $display("FAIL flush_seq1 got %b want 1", rob_reset); end
        @(negedge clock); #1;
        checks++; if (rob_reset !== 1'b0 || disp_ready !== 1'b1) begin errors++; $display("FAIL run_entry got rob_reset=%b ready=%b want 0 1", rob_reset, disp_ready); end
    endtask

    task automatic test_full_pop();
        @(negedge clock);
        rob_full = 1; disp_valid = 1; rob_empty = 0; rob_head_ready = 1; commit_ready = 1; #1;
        checks++; if (rob_push !== 1'b0 || disp_ready !== 1'b0) begin errors++; $display("FAIL full_push got push=%b ready=%b want 0 0", rob_push, disp_ready); end
        checks++; if (rob_pop !== 1'b1) begin errors++; $display("FAIL full_pop got %b want 1", rob_pop); end
        @(negedge clock);
        rob_full = 0; disp_valid = 0; rob_empty = 1; rob_head_ready = 0; commit_ready = 0; #1;
        checks++; if (commit_count !== 32'd1) begin errors++; $display("FAIL full_count got %0d want 1", commit_count); end
    endtask

    task automatic test_rr_all();
        logic [N-1:0] exp_g [4];
        int exp_i [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_i = '{0, 1, 2, 0};
        @(negedge clock); fu_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (fu_grant !== exp_g[c] || rob_finish !== 1'b1) begin errors++; $display("FAIL rr_all%0d grant got %b want %b", c, fu_grant, exp_g[c]); end
            checks++; if (rob_finish_tag !== 32'h100 + exp_i[c] || rob_finish_val !== 32'h200 + exp_i[c]) begin errors++; $display("FAIL rr_all%0d data got %h/%h want %h/%h", c, rob_finish_tag, rob_finish_val, 32'h100 + exp_i[c], 32'h200 + exp_i[c]); end
            @(negedge clock);
        end
        fu_valid = 0;
    endtask

    task automatic test_rr_gap();
        fu_valid = 3'b101; #1;
        checks++; if (fu_grant !== 3'b100 || rob_finish_tag !== 32'h102) begin errors++; $display("FAIL rr_gap0 got %b tag %h want 100 tag 102", fu_grant, rob_finish_tag); end
        @(negedge clock); #1;
        checks++; if (fu_grant !== 3'b001 || rob_finish_tag !== 32'h100) begin errors++; $display("FAIL rr_gap1 got %b tag %h want 001 tag 100", fu_grant, rob_finish_tag); end
        @(negedge clock); fu_valid = 0; #1;
        checks++; if (rob_finish !== 1'b0 || rob_finish_tag !== 32'd0 || rob_finish_val !== 32'd0) begin errors++; $display("FAIL no_grant got fin=%b tag=%h val=%h want 0", rob_finish, rob_finish_tag, rob_finish_val); end
    endtask

    task automatic test_commit_stall();
        @(negedge clock);
        rob_head_instr = 32'hABCD; rob_head_val = 32'h1234; rob_empty = 0; rob_head_ready = 1; commit_ready = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) commit_ready = 1;
            #1;
            checks++; if (commit_valid !== 1'b1 || commit_instr !== 32'hABCD || commit_val !== 32'h1234) begin errors++; $display("FAIL stall%0d got cv=%b instr=%h val=%h want 1 abcd 1234", c, commit_valid, commit_instr, commit_val); end
            checks++; if (rob_pop !== (c == 3)) begin errors++; $display("FAIL stall%0d_pop got %b want %b", c, rob_pop, c == 3); end
            @(negedge clock);
        end
        rob_empty = 1; rob_head_ready = 0; commit_ready = 0; #1;
        checks++; if (commit_count !== 32'd2) begin errors++; $display("FAIL stall_count got %0d want 2", commit_count); end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        disp_valid = 1; disp_instr = 32'h77; fu_valid = 3'b010; rob_empty = 0; rob_head_ready = 1; commit_ready = 1; #1;
        checks++; if (rob_push !== 1'b1 || rob_instr_in !== 32'h77) begin errors++; $display("FAIL b2b_push got %b instr %h want 1 77", rob_push, rob_instr_in); end
        checks++; if (fu_grant !== 3'b010 || rob_pop !== 1'b1) begin errors++; $display("FAIL b2b_fin_pop got grant=%b pop=%b want 010 1", fu_grant, rob_pop); end
        @(negedge clock);
        disp_valid = 0; fu_valid = 0; rob_empty = 1; rob_head_ready = 0; commit_ready = 0; #1;
        checks++; if (commit_count !== 32'd3) begin errors++; $display("FAIL b2b_count got %0d want 3", commit_count); end
    endtask

    task automatic test_flush();
        @(negedge clock);
        flush = 1; disp_valid = 1; fu_valid = 3'b001; rob_empty = 0; rob_head_ready = 1; commit_ready = 1; #1;
        checks++; if (rob_push !== 1'b0 || fu_grant !== 3'b000 || rob_pop !== 1'b0 || rob_reset !== 1'b0) begin errors++; $display("FAIL flush_gate got push=%b grant=%b pop=%b rst=%b want 0 000 0 0", rob_push, fu_grant, rob_pop, rob_reset); end
        @(negedge clock); flush = 0; #1;
        checks++; if (rob_reset !== 1'b1 || fu_grant !== 3'b000 || rob_push !== 1'b0) begin errors++; $display("FAIL flush_hold0 got rst=%b grant=%b push=%b want 1 000 0", rob_reset, fu_grant, rob_push); end
        @(negedge clock); #1;
        checks++; if (rob_reset !== 1'b1) begin errors++; $display("FAIL flush_hold1 got %b want 1", rob_reset); end
        @(negedge clock);
        disp_valid = 0; rob_empty = 1; rob_head_ready = 0; commit_ready = 0; fu_valid = 3'b111; #1;
        checks++; if (rob_reset !== 1'b0 || fu_grant !== 3'b001) begin errors++; $display("FAIL flush_ptr got rst=%b grant=%b want 0 001", rob_reset, fu_grant); end
        checks++; if (commit_count !== 32'd3) begin errors++; $display("FAIL flush_count got %0d want 3", commit_count); end
        @(negedge clock); fu_valid = 0;
    endtask

    initial begin
        test_reset();
        test_full_pop();
        test_rr_all();
        test_rr_gap();
        test_commit_stall();
        test_back_to_back();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
Controller that sequences the reorder buffer (ROB) core.
- Gates dispatch pushes on ROB occupancy.
- Round-robin arbitrates NUM_FU functional-unit completions onto the ROB's single finish port.
- Drives in-order commit to the register file with a valid/ready handshake.
- Sequences ROB clear on flush and after reset, and counts committed instructions.

Parameters:
NUM_FU, 3, number of completion requesters (2..8)
DATA_W, 32, width of instruction tag and value
FLUSH_CYCLES, 2, cycles rob_reset is held after reset or flush (1..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
flush  in  1  pipeline flush request, sampled at posedge
disp_valid  in  1  dispatch has an instruction
disp_instr  in  DATA_W  instruction tag to enqueue
disp_ready  out  1  ROB accepts dispatch this cycle
fu_valid  in  NUM_FU  per-FU completion request
fu_tag  in  NUM_FU*DATA_W  per-FU finishing tag; slice i is bits [i*DATA_W +: DATA_W]
fu_val  in  NUM_FU*DATA_W  per-FU result value, same slicing
fu_grant  out  NUM_FU  one-hot grant; the FU drops its request after a grant
commit_valid  out  1  head is ready to retire
commit_instr  out  DATA_W  retiring tag (= rob_head_instr)
commit_val  out  DATA_W  retiring value (= rob_head_val)
commit_ready  in  1  register file accepts commit
commit_count  out  32  instructions retired since reset
rob_push, rob_pop, rob_finish, rob_reset  out  1  ROB controls
rob_instr_in, rob_finish_tag, rob_finish_val  out  DATA_W  ROB data inputs
rob_head_instr, rob_head_val  in  DATA_W  ROB head
rob_head_ready, rob_full, rob_empty  in  1  ROB status

Behaviour:
State machine, 2 states:
- FLUSH: rob_reset=1; cnt decrements; go to RUN when cnt==1.
- RUN: flush=1 at posedge goes to FLUSH with cnt=FLUSH_CYCLES.

Async reset:
- state=FLUSH, cnt=FLUSH_CYCLES, rr_ptr=0, commit_count=0.
- rob_reset=1 immediately; all handshake outputs are 0.

Gating (combinational):
- "active" = (state==RUN) & !flush.
- Every output below is ANDed with active, so push/pop/finish/grant are 0 in the cycle flush is high.

Dispatch:
- disp_ready = active & !rob_full.
- rob_push = disp_valid & disp_ready; rob_instr_in = disp_instr.
- No push-on-full even with a simultaneous pop.

Finish arbitration:
- Grant the lowest index i such that fu_valid[(rr_ptr+i) mod NUM_FU].
- rob_finish = |fu_grant.
- rob_finish_tag and rob_finish_val come from the granted slice; both are 0 when there is no grant.
- On a grant, rr_ptr <= (granted+1) mod NUM_FU; with no grant, rr_ptr holds.
- On entry to FLUSH, rr_ptr <= 0.

Commit:
- commit_valid = active & !rob_empty & rob_head_ready.
- rob_pop = commit_valid & commit_ready.
- commit_count increments on rob_pop and wraps at 2^32.
- Flush does not clear commit_count.

Simultaneous events:
- push, finish and pop are independent and may all fire in one cycle.
- A finish whose tag matches the head makes commit_valid rise the next cycle, since the ROB registers readiness.

Latency: combinational from ROB status to handshakes; one cycle from finish to a commit-eligible head.

Reset or flush mid-operation: pending grants are dropped. FUs must re-request after flush; no replay.

Decomposition:
- Package rob_pkg: DATA_W default, FLUSH_CYCLES default, state encoding (ST_FLUSH=1'b0, ST_RUN=1'b1).
- Sub-module rr_arbiter (NUM_FU): req in, grant out, registered pointer with advance/clear inputs.
- rob_ctrl holds the FSM, flush counter, muxes and commit counter.

Test Plan:
- Release reset, FLUSH_CYCLES=2 -> rob_reset high through 2 posedges, then 0; disp_ready=1 with rob_full=0.
- rob_full=1, disp_valid=1, rob_empty=0, rob_head_ready=1, commit_ready=1 -> rob_push=0, rob_pop=1, commit_count +1.
- NUM_FU=3, fu_valid=3'b111 held 4 cycles starting rr_ptr=0 -> fu_grant 001,010,100,001; rob_finish_tag tracks the granted slice.
- fu_valid=3'b101 with rr_ptr=1 -> grant 100, then rr_ptr=0, grant 001.
- rob_head_ready=1, commit_ready=0 for 3 cycles, then 1 -> commit_valid high all 4 cycles, commit_instr stable, single rob_pop, count +1.
- flush=1 in the same cycle as disp_valid=1 and fu_valid=001 -> no push or grant; next cycle rob_reset=1 for 2 cycles, rr_ptr=0, commit_count unchanged.
